mem_io_responder: RTL and testbench

// - Memory/IO responder on the far side of the CPU byte bus (mem_a/mem_dout/mem_wr -> cpu_din).
// - Holds program RAM, decodes the I/O window (a[17:16]==2'b11), buffers UART TX bytes,

---
 rtl/mem_io_responder_pkg.sv | 21 ++
 rtl/mem_io_responder_if.sv | 19 +
 rtl/mem_io_responder_byte_fifo.sv | 51 +++++
 rtl/mem_io_responder.sv | 159 +++++++++++++++
 tb/tb_mem_io_responder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address-region decode for the memory/IO responder.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE     = 18'h30000;
    localparam logic [2:0]  IO_PORT_OFS = 3'd0;
    localparam logic [2:0]  IO_CLK_OFS  = 3'd4;
    localparam logic [17:0] RAM_LIMIT   = 18'h20000;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_HOLE,
        RGN_IO
    } region_e;

    function automatic region_e decode_region(input logic [17:0] a);
        if (a[17:16] == IO_BASE[17:16]) return RGN_IO;
        if (a < RAM_LIMIT) return RGN_RAM;
        return RGN_HOLE;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus as seen by the responder: address/data/write strobe in, read data and back-pressure out.
interface mem_io_responder_if;
    logic        rdy_in;
    logic [17:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;

    modport master (
        output rdy_in, cpu_a, cpu_dout, cpu_wr,
        input  cpu_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, cpu_a, cpu_dout, cpu_wr,
        output cpu_din, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide FIFO, power-of-2 depth; push ignored when full, pop ignored when empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/mem_io_responder.sv
// Program RAM + IO window (UART TX/RX, cycle counter) behind the CPU byte bus.
// Optional RX buffering when RESPONDER_RX_FIFO_EN is defined; otherwise rx_data is sampled directly.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
`ifdef RESPONDER_RX_FIFO_EN
    parameter int RX_DEPTH    = 8,
`endif
    parameter int FULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_pop,
    output logic                program_stop,
    output logic                tx_overflow
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    region_e              rgn;
    logic [2:0]           ofs;
    logic                 bus_wr, bus_rd, io_wr_port, io_wr_clk;
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]           tx_din;
    logic [TX_CW-1:0]     tx_cnt, tx_cnt_nxt;
    logic                 rx_avail, rx_take;
    logic [7:0]           rx_byte;
    logic [31:0]          cnt_q, cnt_d, snap_q, snap_d;
    logic [7:0]           io_byte_q, io_byte_d;
    logic                 rd_ram_q, rd_ram_d;
    logic                 io_buffer_full_q, io_buffer_full_d;
    logic                 program_stop_q, program_stop_d;
    logic                 tx_overflow_q, tx_overflow_d;
    logic [7:0]           ram_q [2**RAM_ADDR_W];
    logic [7:0]           ram_rd_q;
    logic [RAM_ADDR_W-1:0] ram_idx;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push),
        .din   (tx_din),
        .pop   (tx_pop),
        .dout  (tx_data),
        .count (tx_cnt),
        .full  (tx_full),
        .empty (tx_empty)
    );

`ifdef RESPONDER_RX_FIFO_EN
    logic                      rx_full, rx_empty;
    logic [$clog2(RX_DEPTH):0] rx_cnt;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_take),
        .dout  (rx_byte),
        .count (rx_cnt),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_avail = ~rx_empty;
    assign rx_pop   = rst_in & rx_valid & ~rx_full;
`else
    assign rx_avail = rx_valid;
    assign rx_byte  = rx_data;
    assign rx_pop   = rst_in & rx_take;
`endif

    assign tx_valid           = ~tx_empty;
    assign ram_idx            = bus.cpu_a[RAM_ADDR_W-1:0];
    assign bus.cpu_din        = rd_ram_q ? ram_rd_q : io_byte_q;
    assign bus.io_buffer_full = io_buffer_full_q;
    assign program_stop       = program_stop_q;
    assign tx_overflow        = tx_overflow_q;

    always_comb begin
        rgn        = decode_region(bus.cpu_a);
        ofs        = bus.cpu_a[2:0];
        bus_wr     = bus.rdy_in & bus.cpu_wr;
        bus_rd     = bus.rdy_in & ~bus.cpu_wr;
        io_wr_port = bus_wr && (rgn == RGN_IO) && (ofs == IO_PORT_OFS);
        io_wr_clk  = bus_wr && (rgn == RGN_IO) && (ofs == IO_CLK_OFS);
        tx_push    = (io_wr_port && (bus.cpu_dout != 8'h00)) || io_wr_clk;
        tx_din     = io_wr_clk ? 8'h00 : bus.cpu_dout;
        // Drain side is independent of rdy_in.
        tx_pop     = tx_valid & tx_ready;
        tx_cnt_nxt = tx_cnt + TX_CW'(tx_push & ~tx_full) - TX_CW'(tx_pop);

        io_buffer_full_d = (TX_CW'(TX_DEPTH) - tx_cnt_nxt) <= TX_CW'(FULL_MARGIN);
        program_stop_d   = program_stop_q | io_wr_clk;
        tx_overflow_d    = tx_overflow_q | (tx_push & tx_full);
        cnt_d            = bus.rdy_in ? cnt_q + 32'd1 : cnt_q;

        snap_d    = snap_q;
        io_byte_d = io_byte_q;
        rd_ram_d  = rd_ram_q;
        rx_take   = 1'b0;
        if (bus_rd) begin
            rd_ram_d  = (rgn == RGN_RAM);
            io_byte_d = 8'h00;
            if (rgn == RGN_IO) begin
                case (ofs)
                    IO_PORT_OFS: begin
                        if (rx_avail) begin
                            io_byte_d = rx_byte;
                            rx_take   = 1'b1;
                        end
                    end
                    IO_CLK_OFS: begin
                        snap_d    = cnt_q;
                        io_byte_d = cnt_q[7:0];
                    end
                    3'd5:    io_byte_d = snap_q[15:8];
                    3'd6:    io_byte_d = snap_q[23:16];
                    3'd7:    io_byte_d = snap_q[31:24];
                    default: io_byte_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q            <= '0;
            snap_q           <= '0;
            io_byte_q        <= '0;
            rd_ram_q         <= 1'b0;
            io_buffer_full_q <= 1'b0;
            program_stop_q   <= 1'b0;
            tx_overflow_q    <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            snap_q           <= snap_d;
            io_byte_q        <= io_byte_d;
            rd_ram_q         <= rd_ram_d;
            io_buffer_full_q <= io_buffer_full_d;
            program_stop_q   <= program_stop_d;
            tx_overflow_q    <= tx_overflow_d;
        end
    end

    // Synchronous-read RAM; cpu_din selects it via rd_ram_q so reset still yields 0.
    always_ff @(posedge clk_in) begin
        if (bus_wr && rgn == RGN_RAM) ram_q[ram_idx] <= bus.cpu_dout;
        if (bus_rd && rgn == RGN_RAM) ram_rd_q <= ram_q[ram_idx];
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed table, hand sequences, random traffic vs a queue model.
module tb_mem_io_responder;

    localparam int TX_DEPTH    = 16;
    localparam int FULL_MARGIN = 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid, rx_pop, program_stop, tx_overflow;

    mem_io_responder_if bus_if();

    mem_io_responder #(
        .RAM_ADDR_W  (17),
        .TX_DEPTH    (TX_DEPTH),
        .FULL_MARGIN (FULL_MARGIN)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus_if),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pop       (rx_pop),
        .program_stop (program_stop),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  m_din;
    bit          m_din_known, m_full, m_ovf, m_stop;

    typedef struct {
        logic [17:0] a;
        bit          wr;
        logic [7:0]  d;
        bit          chk_din;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t        vecs [12];
    logic [17:0] pool [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        txq.delete();
        m_cnt = 0; m_snap = 0; m_din = 0; m_din_known = 1;
        m_full = 0; m_ovf = 0; m_stop = 0;
    endtask

    task automatic model_push(input logic [7:0] b, input bit was_full);
        if (was_full) m_ovf = 1;
        else txq.push_back(b);
    endtask

    // One clock edge of the responder, expressed in terms of the bus rules.
    task automatic model_edge(input bit rdy, input logic [17:0] a, input bit wr, input logic [7:0] d);
        bit was_full;
        int ofs;
        was_full = (txq.size() == TX_DEPTH);
        ofs = int'(a[2:0]);
        if (tx_ready && txq.size() > 0) void'(txq.pop_front());
        if (rdy) begin
            if (wr) begin
                if (a < 18'h20000) ram_m[int'(a)] = d;
                else if (a >= 18'h30000) begin
                    if (ofs == 0 && d != 0) model_push(d, was_full);
                    if (ofs == 4) begin
                        model_push(8'h00, was_full);
                        m_stop = 1;
                    end
                end
            end else begin
                m_din_known = 1;
                if (a < 18'h20000) begin
                    m_din_known = ram_m.exists(int'(a));
                    if (m_din_known) m_din = ram_m[int'(a)];
                end else if (a < 18'h30000) m_din = 0;
                else begin
                    case (ofs)
                        0: m_din = rx_valid ? rx_data : 8'h00;
                        4: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                        5, 6, 7: m_din = 8'(m_snap >> (8 * (ofs - 4)));
                        default: m_din = 0;
                    endcase
                end
            end
            m_cnt = m_cnt + 1;
        end
        m_full = (TX_DEPTH - txq.size()) <= FULL_MARGIN;
    endtask

    task automatic check_outputs();
        if (m_din_known) chk("cpu_din", 32'(bus_if.cpu_din), 32'(m_din));
        chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
        if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
        chk("io_buffer_full", 32'(bus_if.io_buffer_full), 32'(m_full));
        chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
        chk("program_stop", 32'(program_stop), 32'(m_stop));
    endtask

    task automatic step(input bit rdy, input logic [17:0] a, input bit wr, input logic [7:0] d);
        bit exp_pop;
        bus_if.rdy_in   = rdy;
        bus_if.cpu_a    = a;
        bus_if.cpu_wr   = wr;
        bus_if.cpu_dout = d;
        #1;
        exp_pop = rdy && !wr && a[17:16] == 2'b11 && a[2:0] == 3'd0 && rx_valid;
        chk("rx_pop", 32'(rx_pop), 32'(exp_pop));
        @(posedge clk_in);
        model_edge(rdy, a, wr, d);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1, 18'h00010, 0, 8'h00);
    endtask

    task automatic do_reset();
        #2;
        rst_in = 1'b0;
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        bus_if.rdy_in = 0; bus_if.cpu_a = 0; bus_if.cpu_wr = 0; bus_if.cpu_dout = 0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        check_outputs();
        chk("reset_cpu_din", 32'(bus_if.cpu_din), 32'h0);

        // Directed RAM / decode table
        vecs[0]  = '{18'h00010, 1, 8'hA5, 0, 8'h00};
        vecs[1]  = '{18'h00010, 0, 8'h00, 1, 8'hA5};
        vecs[2]  = '{18'h1FFFF, 1, 8'h5A, 0, 8'h00};
        vecs[3]  = '{18'h1FFFF, 0, 8'h00, 1, 8'h5A};
        vecs[4]  = '{18'h20000, 1, 8'h77, 0, 8'h00};
        vecs[5]  = '{18'h20000, 0, 8'h00, 1, 8'h00};
        vecs[6]  = '{18'h00000, 1, 8'h3C, 0, 8'h00};
        vecs[7]  = '{18'h00000, 0, 8'h00, 1, 8'h3C};
        vecs[8]  = '{18'h30001, 0, 8'h00, 1, 8'h00};
        vecs[9]  = '{18'h00010, 0, 8'h00, 1, 8'hA5};
        vecs[10] = '{18'h00010, 1, 8'h11, 0, 8'h00};
        vecs[11] = '{18'h00010, 0, 8'h00, 1, 8'h11};
        tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1, vecs[i].a, vecs[i].wr, vecs[i].d);
            if (vecs[i].chk_din) chk("tbl_din", 32'(bus_if.cpu_din), 32'(vecs[i].exp_din));
        end

        // rdy_in low freezes cpu_din and blocks the RAM write
        step(0, 18'h00000, 0, 8'h00);
        chk("frz_din", 32'(bus_if.cpu_din), 32'h11);
        step(0, 18'h00010, 1, 8'hEE);
        step(1, 18'h00010, 0, 8'h00);
        chk("frz_wr", 32'(bus_if.cpu_din), 32'h11);

        // 'H','i',0x00 to the TX port
        tx_ready = 1'b0;
        step(1, 18'h30000, 1, 8'h48);
        step(1, 18'h30000, 1, 8'h69);
        step(1, 18'h30000, 1, 8'h00);
        chk("hi_valid", 32'(tx_valid), 32'h1);
        chk("hi_first", 32'(tx_data), 32'h48);
        tx_ready = 1'b1;
        idle();
        chk("hi_second", 32'(tx_data), 32'h69);
        idle();
        chk("hi_drained", 32'(tx_valid), 32'h0);

        // Fill TX with the drain stalled
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step(1, 18'h30000, 1, 8'(i));
            if (i == 13) chk("full_at13", 32'(bus_if.io_buffer_full), 32'h0);
            if (i == 14) chk("full_at14", 32'(bus_if.io_buffer_full), 32'h1);
            if (i == 16) chk("ovf_at16", 32'(tx_overflow), 32'h0);
            if (i == 17) chk("ovf_at17", 32'(tx_overflow), 32'h1);
        end

        // Cycle counter after 100 ready cycles
        do_reset();
        tx_ready = 1'b1;
        repeat (100) idle();
        step(1, 18'h30004, 0, 8'h00);
        chk("clk_b0", 32'(bus_if.cpu_din), 32'h64);
        step(1, 18'h30005, 0, 8'h00);
        chk("clk_b1", 32'(bus_if.cpu_din), 32'h00);
        step(1, 18'h30006, 0, 8'h00);
        chk("clk_b2", 32'(bus_if.cpu_din), 32'h00);
        step(1, 18'h30007, 0, 8'h00);
        chk("clk_b3", 32'(bus_if.cpu_din), 32'h00);

        // RX port
        rx_valid = 1'b1; rx_data = 8'h3C;
        bus_if.rdy_in = 1; bus_if.cpu_a = 18'h30000; bus_if.cpu_wr = 0;
        #1;
        chk("rx_pop_hi", 32'(rx_pop), 32'h1);
        step(1, 18'h30000, 0, 8'h00);
        chk("rx_byte", 32'(bus_if.cpu_din), 32'h3C);
        rx_valid = 1'b0;
        step(1, 18'h30000, 0, 8'h00);
        chk("rx_empty", 32'(bus_if.cpu_din), 32'h00);
        chk("rx_pop_lo", 32'(rx_pop), 32'h0);

        // program_stop, then reset in the middle of a burst
        tx_ready = 1'b0;
        step(1, 18'h30004, 1, 8'h99);
        chk("stop_set", 32'(program_stop), 32'h1);
        chk("stop_byte", 32'(tx_data), 32'h00);
        step(1, 18'h30000, 1, 8'h41);
        step(1, 18'h00010, 0, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h5A;
        bus_if.rdy_in = 1; bus_if.cpu_a = 18'h30000; bus_if.cpu_wr = 0;
        #2;
        rst_in = 1'b0;
        #1;
        chk("mid_tx_valid", 32'(tx_valid), 32'h0);
        chk("mid_full", 32'(bus_if.io_buffer_full), 32'h0);
        chk("mid_ovf", 32'(tx_overflow), 32'h0);
        chk("mid_stop", 32'(program_stop), 32'h0);
        chk("mid_din", 32'(bus_if.cpu_din), 32'h0);
        chk("mid_rx_pop", 32'(rx_pop), 32'h0);
        model_reset();
        rx_valid = 1'b0;
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 16; i++) begin
            pool[i] = (i < 8) ? 18'(i * 37) : 18'(18'h1FFF8 + i - 8);
            step(1, pool[i], 1, 8'($urandom));
        end
        for (int i = 0; i < 600; i++) begin
            int          k;
            logic [17:0] a;
            logic [7:0]  d;
            k        = int'($urandom_range(0, 9));
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 2) != 0);
            rx_data  = 8'($urandom);
            if (k < 6)       a = pool[$urandom_range(0, 15)];
            else if (k == 6) a = 18'h20000 + 18'($urandom_range(0, 16'hFFFF));
            else             a = 18'h30000 + 18'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(($urandom_range(0, 6) != 0), a, ($urandom_range(0, 2) == 0), d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
